// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//   Main control FSM for a classic multi-cycle MIPS-style datapath. Each
//   instruction walks FETCH -> DECODE -> (per-class states) -> FETCH. Every
//   control output is decoded from the state register, and from mem_ready in
//   FETCH. The block also produces a one-cycle instr_done pulse, a wrapping
//   retired-instruction counter and a sticky illegal-opcode flag.
//
// Ports
//   clk          : single clock, rising-edge active
//   rst_n        : asynchronous active-low reset
//   opcode[5:0]  : instruction[31:26] held in the IR
//   mem_ready    : memory access completes this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, ALUSrcA, RegWrite, RegDst : 1-bit datapath controls
//   PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0] : 2-bit datapath controls
//   instr_done   : high in the last cycle of every instruction
//   illegal      : sticky, set when the FSM enters TRAP
//   state[3:0]   : current state code
//   instr_count  : retired-instruction counter, CNT_W bits, wraps
// -----------------------------------------------------------------------------
module multicycle_control #(
   parameter logic [5:0]  OP_R         = 6'b000000,
   parameter logic [5:0]  OP_LW        = 6'b100011,
   parameter logic [5:0]  OP_SW        = 6'b101011,
   parameter logic [5:0]  OP_BEQ       = 6'b000100,
   parameter logic [5:0]  OP_J         = 6'b000010,
   parameter logic [5:0]  OP_ADDI      = 6'b001000,
   parameter int unsigned ILLEGAL_TRAP = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             ALUSrcA,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             instr_done,
   output logic             illegal,
   output logic [1:0]       PCSource,
   output logic [1:0]       ALUOp,
   output logic [1:0]       ALUSrcB,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_next_state;
   logic             r_illegal;
   logic [CNT_W-1:0] r_instr_count;
   logic             w_instr_done;

   // Next-state selection; opcode only steers DECODE and MEMADR.
   always_comb begin
      w_next_state = S_FETCH;
      case (r_state)
         S_FETCH:  w_next_state = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            if ((opcode == OP_LW) || (opcode == OP_SW)) begin
               w_next_state = S_MEMADR;
            end else if (opcode == OP_R) begin
               w_next_state = S_EXEC;
            end else if (opcode == OP_BEQ) begin
               w_next_state = S_BRANCH;
            end else if (opcode == OP_J) begin
               w_next_state = S_JUMP;
            end else if (opcode == OP_ADDI) begin
               w_next_state = S_ADDIEX;
            end else begin
               // Undefined opcode: trap forever, or retire as a NOP.
               w_next_state = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
            end
         end
         // IR still holds the opcode, so LW/SW can be split here.
         S_MEMADR: w_next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  w_next_state = S_FETCH;
         S_MEMWR:  w_next_state = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   w_next_state = S_RWB;
         S_RWB:    w_next_state = S_FETCH;
         S_BRANCH: w_next_state = S_FETCH;
         S_JUMP:   w_next_state = S_FETCH;
         S_ADDIEX: w_next_state = S_ADDIWB;
         S_ADDIWB: w_next_state = S_FETCH;
         S_TRAP:   w_next_state = S_TRAP;
         default:  w_next_state = S_FETCH;
      endcase
   end

   // Control decode from the state register; unlisted outputs stay 0.
   always_comb begin
      PCWrite      = 1'b0;
      PCWriteCond  = 1'b0;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      MemtoReg     = 1'b0;
      ALUSrcA      = 1'b0;
      RegWrite     = 1'b0;
      RegDst       = 1'b0;
      PCSource     = 2'b00;
      ALUOp        = 2'b00;
      ALUSrcB      = 2'b00;
      w_instr_done = 1'b0;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
         end
         S_DECODE: begin
            ALUSrcB      = 2'b11;
            // Only an undefined opcode in NOP mode finishes here.
            w_instr_done = (w_next_state == S_FETCH);
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite     = 1'b1;
            MemtoReg     = 1'b1;
            w_instr_done = 1'b1;
         end
         S_MEMWR: begin
            MemWrite     = 1'b1;
            IorD         = 1'b1;
            w_instr_done = mem_ready;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_RWB: begin
            RegWrite     = 1'b1;
            RegDst       = 1'b1;
            w_instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA      = 1'b1;
            ALUOp        = 2'b01;
            PCWriteCond  = 1'b1;
            PCSource     = 2'b01;
            w_instr_done = 1'b1;
         end
         S_JUMP: begin
            PCWrite      = 1'b1;
            PCSource     = 2'b10;
            w_instr_done = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: begin
            RegWrite     = 1'b1;
            w_instr_done = 1'b1;
         end
         S_TRAP: begin
            w_instr_done = 1'b0;
         end
         // Unused codes 13-15 drive nothing and fall back to FETCH.
         default: begin
            w_instr_done = 1'b0;
         end
      endcase
   end

   // State register, sticky illegal flag and retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_FETCH;
         r_illegal     <= 1'b0;
         r_instr_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_next_state == S_TRAP) begin
            r_illegal <= 1'b1;
         end else begin
            r_illegal <= r_illegal;
         end
         // Plain binary add: wraps from all-ones back to zero.
         if (w_instr_done) begin
            r_instr_count <= r_instr_count + CNT_ONE;
         end else begin
            r_instr_count <= r_instr_count;
         end
      end
   end

   assign state       = r_state;
   assign illegal     = r_illegal;
   assign instr_count = r_instr_count;
   assign instr_done  = w_instr_done;

endmodule

// File: tb/tb_multicycle_control.sv
// -----------------------------------------------------------------------------
// tb_multicycle_control
//   Directed bench for multicycle_control. Three instances share the inputs:
//   default parameters, undefined-opcode-as-NOP, and a 2-bit counter.
// -----------------------------------------------------------------------------
module tb_multicycle_control;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   // Control bundle bit order:
   // PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA,
   // RegWrite,RegDst,PCSource[1:0],ALUOp[1:0],ALUSrcB[1:0]
   localparam logic [15:0] C_FETCH0 = 16'b0_0_0_1_0_0_0_0_0_0_00_00_01;
   localparam logic [15:0] C_FETCH1 = 16'b1_0_0_1_0_1_0_0_0_0_00_00_01;
   localparam logic [15:0] C_DECODE = 16'b0_0_0_0_0_0_0_0_0_0_00_00_11;
   localparam logic [15:0] C_MEMADR = 16'b0_0_0_0_0_0_0_1_0_0_00_00_10;
   localparam logic [15:0] C_MEMRD  = 16'b0_0_1_1_0_0_0_0_0_0_00_00_00;
   localparam logic [15:0] C_MEMWB  = 16'b0_0_0_0_0_0_1_0_1_0_00_00_00;
   localparam logic [15:0] C_MEMWR  = 16'b0_0_1_0_1_0_0_0_0_0_00_00_00;
   localparam logic [15:0] C_EXEC   = 16'b0_0_0_0_0_0_0_1_0_0_00_10_00;
   localparam logic [15:0] C_RWB    = 16'b0_0_0_0_0_0_0_0_1_1_00_00_00;
   localparam logic [15:0] C_BRANCH = 16'b0_1_0_0_0_0_0_1_0_0_01_01_00;
   localparam logic [15:0] C_JUMP   = 16'b1_0_0_0_0_0_0_0_0_0_10_00_00;
   localparam logic [15:0] C_ADDIWB = 16'b0_0_0_0_0_0_0_0_1_0_00_00_00;
   localparam logic [15:0] C_ZERO   = 16'b0;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;

   wire [15:0] m_ctl, n_ctl, c_ctl;
   wire        m_done, n_done, c_done;
   wire        m_ill, n_ill, c_ill;
   wire [3:0]  m_state, n_state, c_state;
   wire [15:0] m_cnt, n_cnt;
   wire [1:0]  c_cnt;

   int n_pass  = 0;
   int n_total = 0;

   multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(m_ctl[15]), .PCWriteCond(m_ctl[14]), .IorD(m_ctl[13]),
      .MemRead(m_ctl[12]), .MemWrite(m_ctl[11]), .IRWrite(m_ctl[10]),
      .MemtoReg(m_ctl[9]), .ALUSrcA(m_ctl[8]), .RegWrite(m_ctl[7]),
      .RegDst(m_ctl[6]), .PCSource(m_ctl[5:4]), .ALUOp(m_ctl[3:2]),
      .ALUSrcB(m_ctl[1:0]), .instr_done(m_done), .illegal(m_ill),
      .state(m_state), .instr_count(m_cnt)
   );

   multicycle_control #(.ILLEGAL_TRAP(0)) dut_nop (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(n_ctl[15]), .PCWriteCond(n_ctl[14]), .IorD(n_ctl[13]),
      .MemRead(n_ctl[12]), .MemWrite(n_ctl[11]), .IRWrite(n_ctl[10]),
      .MemtoReg(n_ctl[9]), .ALUSrcA(n_ctl[8]), .RegWrite(n_ctl[7]),
      .RegDst(n_ctl[6]), .PCSource(n_ctl[5:4]), .ALUOp(n_ctl[3:2]),
      .ALUSrcB(n_ctl[1:0]), .instr_done(n_done), .illegal(n_ill),
      .state(n_state), .instr_count(n_cnt)
   );

   multicycle_control #(.CNT_W(2)) dut_c2 (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(c_ctl[15]), .PCWriteCond(c_ctl[14]), .IorD(c_ctl[13]),
      .MemRead(c_ctl[12]), .MemWrite(c_ctl[11]), .IRWrite(c_ctl[10]),
      .MemtoReg(c_ctl[9]), .ALUSrcA(c_ctl[8]), .RegWrite(c_ctl[7]),
      .RegDst(c_ctl[6]), .PCSource(c_ctl[5:4]), .ALUOp(c_ctl[3:2]),
      .ALUSrcB(c_ctl[1:0]), .instr_done(c_done), .illegal(c_ill),
      .state(c_state), .instr_count(c_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic        mr;
      logic [3:0]  st;
      logic [15:0] ctl;
      logic        done;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [5:0] op, input logic mr, input logic [3:0] st,
                      input logic [15:0] ctl, input logic done, input logic [15:0] cnt);
      vec_t v;
      v.op = op; v.mr = mr; v.st = st; v.ctl = ctl; v.done = done; v.cnt = cnt;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply inputs on the falling edge and settle before sampling.
   task automatic cyc(input logic [5:0] op, input logic mr);
      @(negedge clk);
      opcode    = op;
      mem_ready = mr;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      mem_ready = 1'b0;
      rst_n     = 1'b0;
      @(negedge clk);
      rst_n     = 1'b1;
   endtask

   int c2_exp[5] = '{1, 2, 3, 0, 1};

   initial begin
      rst_n     = 1'b1;
      opcode    = OP_R;
      mem_ready = 1'b0;

      // Cycle table from reset; cnt is the main counter during that row.
      add(OP_LW,   1'b1, 4'd0,  C_FETCH1, 1'b0, 16'd0);
      add(OP_LW,   1'b1, 4'd1,  C_DECODE, 1'b0, 16'd0);
      add(OP_LW,   1'b1, 4'd2,  C_MEMADR, 1'b0, 16'd0);
      add(OP_LW,   1'b1, 4'd3,  C_MEMRD,  1'b0, 16'd0);
      add(OP_LW,   1'b1, 4'd4,  C_MEMWB,  1'b1, 16'd0);
      add(OP_SW,   1'b0, 4'd0,  C_FETCH0, 1'b0, 16'd1);
      add(OP_SW,   1'b1, 4'd0,  C_FETCH1, 1'b0, 16'd1);
      add(OP_SW,   1'b1, 4'd1,  C_DECODE, 1'b0, 16'd1);
      add(OP_SW,   1'b1, 4'd2,  C_MEMADR, 1'b0, 16'd1);
      add(OP_SW,   1'b0, 4'd5,  C_MEMWR,  1'b0, 16'd1);
      add(OP_SW,   1'b0, 4'd5,  C_MEMWR,  1'b0, 16'd1);
      add(OP_SW,   1'b0, 4'd5,  C_MEMWR,  1'b0, 16'd1);
      add(OP_SW,   1'b1, 4'd5,  C_MEMWR,  1'b1, 16'd1);
      add(OP_R,    1'b1, 4'd0,  C_FETCH1, 1'b0, 16'd2);
      add(OP_R,    1'b1, 4'd1,  C_DECODE, 1'b0, 16'd2);
      add(OP_R,    1'b1, 4'd6,  C_EXEC,   1'b0, 16'd2);
      add(OP_R,    1'b1, 4'd7,  C_RWB,    1'b1, 16'd2);
      add(OP_ADDI, 1'b1, 4'd0,  C_FETCH1, 1'b0, 16'd3);
      add(OP_ADDI, 1'b1, 4'd1,  C_DECODE, 1'b0, 16'd3);
      add(OP_ADDI, 1'b1, 4'd10, C_MEMADR, 1'b0, 16'd3);
      add(OP_ADDI, 1'b1, 4'd11, C_ADDIWB, 1'b1, 16'd3);
      add(OP_BEQ,  1'b1, 4'd0,  C_FETCH1, 1'b0, 16'd4);
      add(OP_BEQ,  1'b1, 4'd1,  C_DECODE, 1'b0, 16'd4);
      add(OP_BEQ,  1'b1, 4'd8,  C_BRANCH, 1'b1, 16'd4);
      add(OP_J,    1'b1, 4'd0,  C_FETCH1, 1'b0, 16'd5);
      add(OP_J,    1'b1, 4'd1,  C_DECODE, 1'b0, 16'd5);
      add(OP_J,    1'b1, 4'd9,  C_JUMP,   1'b1, 16'd5);
      add(OP_LW,   1'b1, 4'd0,  C_FETCH1, 1'b0, 16'd6);
      add(OP_LW,   1'b1, 4'd1,  C_DECODE, 1'b0, 16'd6);
      add(OP_LW,   1'b1, 4'd2,  C_MEMADR, 1'b0, 16'd6);
      add(OP_LW,   1'b0, 4'd3,  C_MEMRD,  1'b0, 16'd6);
      add(OP_LW,   1'b1, 4'd3,  C_MEMRD,  1'b0, 16'd6);
      add(OP_LW,   1'b1, 4'd4,  C_MEMWB,  1'b1, 16'd6);
      add(OP_R,    1'b0, 4'd0,  C_FETCH0, 1'b0, 16'd7);

      // Reset state, including FETCH decode while reset is held.
      #1 rst_n = 1'b0;
      #2;
      chk("reset state", m_state, 4'd0);
      chk("reset ctl", m_ctl, C_FETCH0);
      chk("reset count", m_cnt, 16'd0);
      chk("reset illegal", m_ill, 1'b0);
      chk("reset done", m_done, 1'b0);
      mem_ready = 1'b1;
      #1;
      chk("reset ctl ready", m_ctl, C_FETCH1);
      mem_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].op, tbl[i].mr);
         chk($sformatf("row%0d state", i), m_state, tbl[i].st);
         chk($sformatf("row%0d ctl", i), m_ctl, tbl[i].ctl);
         chk($sformatf("row%0d done", i), m_done, tbl[i].done);
         chk($sformatf("row%0d count", i), m_cnt, tbl[i].cnt);
         chk($sformatf("row%0d illegal", i), m_ill, 1'b0);
         chk($sformatf("row%0d nop state", i), n_state, tbl[i].st);
      end

      // 2-bit counter wraps: 1,2,3,0,1 over five R-type instructions.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         repeat (4) cyc(OP_R, 1'b1);
         chk($sformatf("c2 done%0d", k), c_done, 1'b1);
         @(posedge clk);
         #1;
         chk($sformatf("c2 count%0d", k), c_cnt, c2_exp[k]);
         chk($sformatf("main count%0d", k), m_cnt, k + 1);
      end

      // Undefined opcode: trap instance vs NOP instance.
      do_reset();
      cyc(OP_BAD, 1'b1);
      cyc(OP_BAD, 1'b1);
      chk("bad decode done trap", m_done, 1'b0);
      chk("bad decode done nop", n_done, 1'b1);
      chk("bad decode illegal", m_ill, 1'b0);
      @(posedge clk);
      #1;
      chk("trap state", m_state, 4'd12);
      chk("trap illegal", m_ill, 1'b1);
      chk("nop state", n_state, 4'd0);
      chk("nop illegal", n_ill, 1'b0);
      chk("nop count", n_cnt, 16'd1);
      for (int k = 0; k < 3; k++) begin
         cyc(OP_R, k[0]);
         chk($sformatf("trap hold state%0d", k), m_state, 4'd12);
         chk($sformatf("trap hold ctl%0d", k), m_ctl, C_ZERO);
         chk($sformatf("trap hold done%0d", k), m_done, 1'b0);
         chk($sformatf("trap hold illegal%0d", k), m_ill, 1'b1);
         chk($sformatf("trap hold count%0d", k), m_cnt, 16'd0);
      end
      // Reset clears illegal asynchronously, before any clock edge.
      @(negedge clk);
      mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("trap reset state", m_state, 4'd0);
      chk("trap reset illegal", m_ill, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset pulsed in the middle of a load's MEMRD wait.
      repeat (3) cyc(OP_J, 1'b1);
      cyc(OP_LW, 1'b1);
      cyc(OP_LW, 1'b1);
      cyc(OP_LW, 1'b1);
      cyc(OP_LW, 1'b0);
      chk("memrd state", m_state, 4'd3);
      chk("memrd count", m_cnt, 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset state", m_state, 4'd0);
      chk("mid reset count", m_cnt, 16'd0);
      chk("mid reset illegal", m_ill, 1'b0);
      chk("mid reset ctl", m_ctl, C_FETCH0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(OP_R, 1'b1);
      chk("post reset state", m_state, 4'd0);
      chk("post reset ctl", m_ctl, C_FETCH1);
      @(posedge clk);
      #1;
      chk("post reset decode", m_state, 4'd1);
      chk("post reset count", m_cnt, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
